// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC round-robin channel scheduler.
// Holds the FSM state encoding, the channel-select width and the sentinel
// value driven on the channel select when no channel is being converted.
package adc_sched_pkg;

    localparam int NUM_ADC_CH = 15;
    localparam int ADC_W      = 10;

    typedef logic [3:0] ch_t;

    // Channel select value meaning "no channel selected".
    localparam ch_t CH_NONE = 4'hF;

    // Pointer value after reset: the search starts at ptr+1, so the first
    // channel picked after reset is the lowest enabled one.
    localparam ch_t PTR_RESET = 4'(NUM_ADC_CH - 1);

    // Scheduler states.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_ADVANCE = 2'd3;

endpackage

// File: rtl/adc_rr_next.sv
// Combinational round-robin finder.
// Looks for the first set bit of ch_mask in the order ptr+1, ptr+2, ...,
// wrapping from 14 back to 0 and ending at ptr itself.
// Ports:
//   ch_mask  in   15  enabled-channel mask
//   ptr      in   4   last channel served (0..14)
//   nxt      out  4   next channel to serve (CH_NONE when none)
//   found    out  1   at least one channel is enabled
module adc_rr_next
    import adc_sched_pkg::*;
(
    input  logic [NUM_ADC_CH-1:0] ch_mask,
    input  ch_t                   ptr,
    output ch_t                   nxt,
    output logic                  found
);

    // cand[k] is the channel visited at search step k (ptr+1+k modulo 15);
    // rot[k] tells whether that channel is enabled.
    ch_t                   cand [NUM_ADC_CH];
    logic [NUM_ADC_CH-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ADC_CH; gi++) begin : g_cand
            logic [4:0] sum;
            assign sum = {1'b0, ptr} + 5'(gi + 1);
            // Double wrap keeps the index in range even if ptr were ever 15.
            assign cand[gi] = (sum >= 5'd30) ? 4'(sum - 5'd30) :
                              (sum >= 5'd15) ? 4'(sum - 5'd15) : sum[3:0];
            assign rot[gi]  = ch_mask[cand[gi]];
        end
    endgenerate

    // Priority pick: scanning downwards lets the lowest search step win.
    always_comb begin
        found = 1'b0;
        nxt   = CH_NONE;
        for (int k = NUM_ADC_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                nxt   = cand[k];
            end
        end
    end

endmodule

// File: rtl/adc_channel_scheduler.sv
// Round-robin sequencer for the AVR-side ADC.
// Steps the channel select through the enabled channels; for each channel it
// holds the select for a settle window (samples ignored), then captures the
// first sample tagged with the selected channel, or gives up after a timeout.
// Ports:
//   clk             in   1   system clock
//   rst_n           in   1   asynchronous active-low reset
//   enable          in   1   scheduler run enable
//   ch_mask         in   15  bit i enables ADC channel i
//   channel         out  4   channel select to the AVR interface (F = none)
//   new_sample      in   1   one-cycle sample strobe from the AVR interface
//   sample          in   10  ADC value, valid with new_sample
//   sample_channel  in   4   channel tag, valid with new_sample
//   result_valid    out  1   one-cycle pulse when a result is captured
//   result_channel  out  4   channel of the captured result (held)
//   result_data     out  10  captured sample value (held)
//   timeout_err     out  1   one-cycle pulse when a channel times out
//   busy            out  1   high in any state other than IDLE
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_ADC_CH-1:0] ch_mask,
    output logic [3:0]            channel,
    input  logic                  new_sample,
    input  logic [ADC_W-1:0]      sample,
    input  logic [3:0]            sample_channel,
    output logic                  result_valid,
    output logic [3:0]            result_channel,
    output logic [ADC_W-1:0]      result_data,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_reg;
    ch_t              ptr_reg;
    logic [CNT_W-1:0] cnt_reg;

    ch_t  nxt;
    logic found;

    adc_rr_next u_rr_next (
        .ch_mask (ch_mask),
        .ptr     (ptr_reg),
        .nxt     (nxt),
        .found   (found)
    );

    // One counter serves both the settle window and the wait timeout; it is
    // cleared on every channel selection and on the SETTLE->WAIT hand-over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            channel        <= CH_NONE;
            ptr_reg        <= PTR_RESET;
            cnt_reg        <= '0;
            result_valid   <= 1'b0;
            result_channel <= '0;
            result_data    <= '0;
            timeout_err    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            case (state_reg)
                // IDLE and ADVANCE both (re)sample ch_mask and pick the next
                // channel; a single enabled channel is simply picked again.
                ST_IDLE, ST_ADVANCE: begin
                    if (enable && found) begin
                        channel   <= nxt;
                        ptr_reg   <= nxt;
                        cnt_reg   <= '0;
                        state_reg <= ST_SETTLE;
                    end else begin
                        channel   <= CH_NONE;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (!enable) begin
                        channel   <= CH_NONE;
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == SETTLE_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        channel   <= CH_NONE;
                        state_reg <= ST_IDLE;
                    end else if (new_sample && (sample_channel == channel)) begin
                        // Checked before the terminal count so a match on the
                        // last cycle is reported as a result, not a timeout.
                        result_valid   <= 1'b1;
                        result_data    <= sample;
                        result_channel <= channel;
                        state_reg      <= ST_ADVANCE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        state_reg   <= ST_ADVANCE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    channel   <= CH_NONE;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Self-checking bench for adc_channel_scheduler (SETTLE_CYCLES=4, TIMEOUT_CYCLES=16).
// A driver plays the AVR interface one channel visit at a time: it predicts the
// selected channel with a plain round-robin search over the mask, plans the
// samples it will return, works out from the settle/timeout windows whether the
// visit ends in a result or a timeout (and on which cycle), and queues that
// expectation. A separate monitor pops the queue on every result/timeout pulse.
module tb_adc_channel_scheduler;

    localparam int S  = 4;
    localparam int TO = 16;

    localparam int M_RAND    = 0;  // random tagged samples, first one inside the settle window
    localparam int M_TAG_MIX = 1;  // foreign tag 5, then own tag with 10'h3FF
    localparam int M_SILENT  = 2;  // no samples: timeout
    localparam int M_TERM    = 3;  // own sample exactly on the terminal timeout cycle
    localparam int M_ABORT   = 4;  // enable dropped during WAIT
    localparam int M_RESET   = 5;  // asynchronous reset during WAIT

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [14:0] ch_mask;
    logic [3:0]  channel;
    logic        new_sample;
    logic [9:0]  sample;
    logic [3:0]  sample_channel;
    logic        result_valid;
    logic [3:0]  result_channel;
    logic [9:0]  result_data;
    logic        timeout_err;
    logic        busy;

    always #5 clk = ~clk;

    adc_channel_scheduler #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .ch_mask        (ch_mask),
        .channel        (channel),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .result_valid   (result_valid),
        .result_channel (result_channel),
        .result_data    (result_data),
        .timeout_err    (timeout_err),
        .busy           (busy)
    );

    typedef struct {
        bit is_to;
        int ch;
        int data;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   model_ptr = 14;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference round-robin: first enabled channel after 'last', wrapping 14->0.
    function automatic int rr_next(input logic [14:0] m, input int last);
        for (int k = 1; k <= 15; k++) begin
            int idx;
            idx = (last + k) % 15;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    // Monitor: every pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (result_valid || timeout_err)) begin
                $display("[cyc %0d] pulse rv=%0b to=%0b ch=%0d data=0x%03h",
                         cyc, result_valid, timeout_err,
                         result_valid ? result_channel : channel, result_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", int'({result_valid, timeout_err}), e.is_to ? 1 : 2);
                    chk("pulse_cycle", cyc, e.at);
                    if (e.is_to) begin
                        chk("timeout_channel", int'(channel), e.ch);
                    end else begin
                        chk("result_channel", int'(result_channel), e.ch);
                        chk("result_data", int'(result_data), e.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Called at the negedge before the first SETTLE cycle: the DUT picks the
    // channel on the coming edge.
    task automatic start_run(input logic [14:0] m);
        ch_mask = m;
        enable  = 1'b1;
        @(negedge clk);
    endtask

    // Entered at the negedge of the first SETTLE cycle of a visit (offset 0).
    // Offsets 0..S-1 are SETTLE, S..S+TO-1 are WAIT. A sample driven at offset
    // d is seen at the end of that cycle, so a capture shows at offset d+1;
    // a timeout shows at offset S+TO (counting offset 0 as cycle 1, that is
    // cycle 4 + 16 + 1). Normal visits return at the next visit's offset 0.
    task automatic do_visit(input int mode, input logic [14:0] next_mask);
        int   c, ts, p, n, stop;
        int   eo[3];
        int   et[3];
        int   ev[3];
        bit   hit;
        exp_t e;

        c = rr_next(ch_mask, model_ptr);
        model_ptr = c;
        ts = cyc;
        chk("visit_channel", int'(channel), c);
        chk("visit_busy", int'(busy), 1);

        n = 0;
        case (mode)
            M_RAND: begin
                eo[0] = 2;
                et[0] = c;
                ev[0] = int'($urandom_range(0, 1023));
                eo[1] = eo[0] + int'($urandom_range(1, 8));
                et[1] = ($urandom_range(0, 1) != 0) ? c : (c + 1 + int'($urandom_range(0, 13))) % 15;
                ev[1] = int'($urandom_range(0, 1023));
                eo[2] = eo[1] + int'($urandom_range(1, 14));
                et[2] = c;
                ev[2] = int'($urandom_range(0, 1023));
                n = 3;
            end
            M_TAG_MIX: begin
                eo[0] = S + 1; et[0] = 5; ev[0] = int'($urandom_range(0, 1023));
                eo[1] = S + 3; et[1] = c; ev[1] = 10'h3FF;
                n = 2;
            end
            M_TERM: begin
                eo[0] = S + TO - 2; et[0] = (c + 7) % 15; ev[0] = int'($urandom_range(0, 1023));
                eo[1] = S + TO - 1; et[1] = c;            ev[1] = int'($urandom_range(0, 1023));
                n = 2;
            end
            default: n = 0;
        endcase

        // First own-tag sample inside the WAIT window wins; otherwise timeout.
        hit = 1'b0;
        p = S + TO;
        e.data = 0;
        for (int i = 0; i < n; i++) begin
            if (!hit && et[i] == c && eo[i] >= S && eo[i] < S + TO) begin
                hit = 1'b1;
                p = eo[i] + 1;
                e.data = ev[i];
            end
        end

        if (mode == M_ABORT || mode == M_RESET) begin
            stop = S + 3;
        end else begin
            stop = p;
            e.is_to = !hit;
            e.ch = c;
            e.at = ts + p;
            exp_q.push_back(e);
        end

        for (int off = 0; off < stop; off++) begin
            new_sample = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (eo[i] == off) begin
                    new_sample     = 1'b1;
                    sample_channel = 4'(et[i]);
                    sample         = 10'(ev[i]);
                end
            end
            if (off == 1) ch_mask = next_mask;
            if (mode == M_ABORT && off == stop - 1) enable = 1'b0;
            if (mode != M_ABORT && mode != M_RESET && off == stop - 1)
                chk("channel_stable", int'(channel), c);
            @(negedge clk);
        end
        new_sample = 1'b0;

        if (mode == M_ABORT) begin
            chk("abort_channel", int'(channel), 15);
            chk("abort_busy", int'(busy), 0);
            repeat (3) @(negedge clk);
        end else if (mode == M_RESET) begin
            #2;
            rst_n  = 1'b0;
            enable = 1'b0;
            #1;
            chk("areset_channel", int'(channel), 15);
            chk("areset_busy", int'(busy), 0);
            chk("areset_result_valid", int'(result_valid), 0);
            chk("areset_result_channel", int'(result_channel), 0);
            chk("areset_result_data", int'(result_data), 0);
            chk("areset_timeout_err", int'(timeout_err), 0);
            model_ptr = 14;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        ch_mask        = '0;
        new_sample     = 1'b0;
        sample         = '0;
        sample_channel = '0;

        @(negedge clk);
        chk("reset_channel", int'(channel), 15);
        chk("reset_busy", int'(busy), 0);
        chk("reset_result_valid", int'(result_valid), 0);
        chk("reset_result_channel", int'(result_channel), 0);
        chk("reset_result_data", int'(result_data), 0);
        chk("reset_timeout_err", int'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two channels alternate: 0,4,0,4,...
        start_run(15'h0011);
        for (int i = 0; i < 6; i++)
            do_visit(M_RAND, (i == 5) ? 15'h0004 : 15'h0011);

        // Single channel 2: foreign tag ignored, then re-selected.
        do_visit(M_TAG_MIX, 15'h0004);
        do_visit(M_RAND, 15'h0004);
        do_visit(M_RAND, 15'h0002);

        // Silent channel 1 times out and is re-selected.
        do_visit(M_SILENT, 15'h0002);
        do_visit(M_SILENT, 15'h0002);
        // Match on the terminal timeout cycle.
        do_visit(M_TERM, 15'h0008);

        // Abort on channel 3 during WAIT, resume with mask {3,4}: next is 4.
        do_visit(M_ABORT, 15'h0008);
        start_run(15'h0018);
        for (int i = 0; i < 3; i++) do_visit(M_RAND, 15'h0018);
        for (int i = 0; i < 8; i++)
            do_visit(M_RAND, 15'($urandom_range(1, 32767)));
        do_visit(M_ABORT, ch_mask);

        // Empty mask with enable high: scheduler stays idle.
        ch_mask = '0;
        enable  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("empty_mask_busy", int'(busy), 0);
            chk("empty_mask_channel", int'(channel), 15);
        end

        // Reset in WAIT on channel 6; afterwards the lowest bit (6) comes first,
        // not the one after the old pointer (9).
        start_run(15'h0040);
        do_visit(M_RESET, 15'h0240);
        start_run(15'h0240);
        do_visit(M_RAND, 15'h0240);
        do_visit(M_RAND, 15'h0240);
        do_visit(M_ABORT, 15'h0240);

        repeat (3) @(negedge clk);
        chk("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
